// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module alu_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OP_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [OP_W-1:0] req0_op,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [OP_W-1:0] req1_op,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            rsp_err,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [OP_W-1:0] alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  localparam logic [OP_W-1:0] OpAdd = OP_W'(0);
  localparam logic [OP_W-1:0] OpSub = OP_W'(1);
  localparam logic [OP_W-1:0] OpAnd = OP_W'(2);
  localparam logic [OP_W-1:0] OpOr  = OP_W'(3);
  localparam logic [OP_W-1:0] OpSlt = OP_W'(4);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic            owner_ready;
  logic            slot_free;
  logic            grant0, grant1, grant;
  logic [OP_W-1:0] sel_op;
  logic            sel_legal;

  always_comb begin
    owner_ready = owner_q ? rsp1_ready : rsp0_ready;
    // No grant may be issued while reset is held, even though the slot reads empty.
    slot_free   = !reset && ((state_q == StIdle) || owner_ready);
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = slot_free && req0_valid;
    grant1 = slot_free && req1_valid && !req0_valid;
  end
`else
  logic last_grant_q, last_grant_d;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0       = slot_free && req0_valid && (!req1_valid || last_grant_q);
    grant1       = slot_free && req1_valid && (!req0_valid || !last_grant_q);
    last_grant_d = grant ? grant1 : last_grant_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    grant      = grant0 || grant1;
    req0_ready = grant0;
    req1_ready = grant1;
    sel_op     = grant1 ? req1_op : req0_op;
    sel_legal  = (sel_op == OpAdd) || (sel_op == OpSub) || (sel_op == OpAnd) ||
                 (sel_op == OpOr)  || (sel_op == OpSlt);
  end

  // Illegal opcodes and idle cycles present a harmless ADD of zeros to the ALU.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = OpAdd;
    if (grant && sel_legal) begin
      alu_a       = grant1 ? req1_a : req0_a;
      alu_b       = grant1 ? req1_b : req0_b;
      alu_control = sel_op;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    if (grant) begin
      state_d  = StHold;
      owner_d  = grant1;
      result_d = sel_legal ? alu_result : '0;
      zero_d   = sel_legal ? alu_zero : 1'b0;
      err_d    = !sel_legal;
    end else if ((state_q == StHold) && owner_ready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    rsp0_valid = (state_q == StHold) && !owner_q;
    rsp1_valid = (state_q == StHold) && owner_q;
    rsp_result = result_q;
    rsp_zero   = zero_q;
    rsp_err    = err_q;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the core datapath port and an address/debug unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Requests are granted round-robin, one outstanding at a time. The ALU result is captured into a response register that holds until the owning requester accepts it.

Parameters:
XLEN, 32, operand/result width; must match ALU width
OP_W, 3, width of ALU control code

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  XLEN  requester 0 operand A
req0_b  input  XLEN  requester 0 operand B
req0_op  input  OP_W  requester 0 ALU control code
rsp0_valid  output  1  response for requester 0 held
rsp0_ready  input  1  requester 0 consumes response
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
rsp1_valid, rsp1_ready  same as requester 0, for requester 1
rsp_result  output  XLEN  registered result, shared by both response channels
rsp_zero  output  1  registered zero flag
rsp_err  output  1  registered illegal-opcode flag
alu_a  output  XLEN  to ALU operand A
alu_b  output  XLEN  to ALU operand B
alu_control  output  OP_W  to ALU control
alu_result  input  XLEN  from ALU
alu_zero  input  1  from ALU

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - rsp0_valid = rsp1_valid = 0.
  - rsp_result = 0, rsp_zero = 0, rsp_err = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- States:
  - IDLE: response slot empty.
  - HOLD: slot full, owner in rsp_owner register.
- Slot is free this cycle if the state is IDLE, or the state is HOLD and the owner's rsp_ready = 1.
- Grant (combinational, only when slot is free):
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester != last_grant is granted.
- Granted requester: reqN_ready = 1 in that cycle. Other ready = 0. Both readies are 0 when the slot is not free.
- ALU drive:
  - During a grant: alu_a/alu_b/alu_control = the granted requester's operands, same cycle.
  - Otherwise: alu_a = 0, alu_b = 0, alu_control = ADD code. The ALU never sees X or a latched stale code.
- Capture on the grant edge:
  - rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_err <= 0.
  - rsp_owner <= grantee, last_grant <= grantee, state <= HOLD.
  - rspN_valid = 1 for the owner only.
- Illegal opcodes:
  - Legal ops: ADD, SUB, AND, OR, SLT.
  - Any other op is still accepted, but capture stores result 0, zero 0, err 1, and ALU inputs are driven with the idle values.
- Latency: one cycle from request handshake to rspN_valid. Back-to-back throughput is 1 op/cycle when the owner holds rsp_ready high.
- Response handshake:
  - Owner's rsp_ready = 1 in HOLD completes the response.
  - With no simultaneous grant: state <= IDLE, rspN_valid <= 0, result registers keep their value.
  - With a simultaneous grant: new capture and owner, state stays HOLD.
- rsp_ready of the non-owner is ignored.
- reqN_* must stay stable while valid and not ready. The arbiter does not check this.
- Reset mid-operation: any held response is discarded, no ready is asserted during reset, and the first grant after reset follows the reset last_grant.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins ties and last_grant is not implemented. Requester 1 is granted only when req0_valid = 0.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then req0 ADD a=5 b=7, rsp0_ready=1 -> req0_ready same cycle; next cycle rsp0_valid=1, rsp_result=12, rsp_zero=0; rsp1_valid=0.
- Both valid every cycle (req0 SUB 9-9, req1 OR 0xF0|0x0F), both rsp_ready=1 -> grants alternate 0,1,0,1; responses: result 0 zero 1, then 0xFF zero 0.
- req0 SLT 3<4, rsp0_ready=0 for 3 cycles -> rsp0_valid and result 1 held; req1_valid=1 sees req1_ready=0 until the cycle rsp0_ready rises, then is granted that same cycle.
- req1 op=7 -> accepted; rsp1_valid=1, rsp_result=0, rsp_err=1; alu_control = ADD code that cycle.
- Reset asserted while rsp0_valid=1 -> rsp0_valid=0 immediately, without waiting for a clock edge; after release, both valid -> requester 0 granted first.
- With ALU_ARB_FIXED_PRIO_EN, both valid continuously with ready -> requester 0 granted every cycle; requester 1 granted only once req0_valid drops.
